ifetch_ctrl: RTL
================

// Module: ifetch_ctrl
// PURPOSE
//  Sequences the instruction memory for the miniRV core.
//  - Owns the PC and drives the byte address into the combinational instruction memory.
//  - Captures the returned word into a registered IF/ID output stage with a valid/ready handshake.
//  - Handles branch/jump redirects from execute, halts on EBREAK and faults on illegal fetch addresses.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  IMEM_WORDS 32             instruction memory depth in words; legal PC < IMEM_WORDS*4
// PORTS
//  clk             in   1   single clock; all state updates on rising edge
//  rst_n           in   1   synchronous, active-low reset
//  imem_addr       out  32  byte address to instruction memory (= pc, combinational)
//  imem_rdata      in   32  instruction word returned combinationally for imem_addr
//  out_valid       out  1   out_inst/out_pc hold a fetched instruction
//  out_ready       in   1   decode accepts out_* this cycle
//  out_inst        out  32  fetched instruction
//  out_pc          out  32  byte address of out_inst
//  redirect_valid  in   1   execute requests fetch from redirect_pc
//  redirect_pc     in   32  redirect target (byte address)
//  resume          in   1   leave HALT and continue fetching at pc
//  halted          out  1   state == HALT
//  fault           out  1   state == FAULT
//  fetch_count     out  32  instructions loaded into output stage; wraps mod 2^32
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//   - state=BOOT, pc=RESET_PC, out_valid=0, out_inst=0, out_pc=0, fetch_count=0.
//   - halted=0, fault=0. Applies mid-operation; any in-flight instruction is discarded.
//  States: BOOT -> RUN (unconditional, 1 cycle; no fetch in BOOT). RUN, HALT, FAULT.
//  load = (state==RUN) && !redirect_valid && pc_legal && (!out_valid || out_ready).
//   - pc_legal = pc < IMEM_WORDS*4.
//   - pc[1:0] is always 0 by construction.
//  On load:
//   - out_inst<=imem_rdata, out_pc<=pc, out_valid<=1.
//   - pc<=pc+4 (32-bit wrap), fetch_count+=1.
//   - Latency: instruction visible on out_* 1 cycle after its address is driven.
//   - Throughput: 1 instruction/cycle while out_ready=1.
//  Handshake:
//   - If out_valid && !out_ready, out_* held stable; pc held.
//   - If out_valid && out_ready && !load, out_valid<=0.
//  Redirect (RUN, highest priority, beats load/EBREAK/illegal pc):
//   - out_valid<=0 (flush), fetch_count unchanged.
//   - redirect_pc[1:0]==0: pc<=redirect_pc.
//   - Otherwise: state<=FAULT, pc unchanged.
//   - First instruction from target appears on out_* 2 cycles after redirect asserted.
//  EBREAK:
//   - Loaded word == 32'h0010_0073 -> state<=HALT in same edge; pc already advanced past it.
//   - In HALT: no loads; out_valid/out_* obey handshake so decode can drain the EBREAK.
//   - resume && !redirect_valid -> RUN.
//   - redirect_valid in HALT is ignored.
//  Illegal address:
//   - RUN with !pc_legal and no redirect -> state<=FAULT, no load.
//   - FAULT exits only by reset; out_* drain via handshake, no new loads.
//  Same-cycle events: redirect > fault detection > load; resume is only sampled in HALT.
// STRUCTURE
//  - Package minirv_pkg: typedef enum logic[1:0] {BOOT,RUN,HALT,FAULT} fetch_state_t.
//  - Package minirv_pkg: localparam INST_EBREAK=32'h0010_0073; localparam INST_NOP=32'h0000_0013.
//  - One natural sub-module: ifetch_out_reg (valid/ready output register with flush input); rest inline.
// TESTING
//  1. Reset, out_ready=1, imem holds 4 NOPs @0..12
//     -> out_valid rises 2 cycles after reset release; out_pc 0,4,8,12 on consecutive cycles.
//     -> fetch_count increments by 1 per cycle.
//  2. out_ready=0 for 3 cycles with out_pc=4
//     -> out_pc/out_inst stable, imem_addr stays 8; release -> out_pc=8 next cycle, no skip/dup.
//  3. redirect_valid with redirect_pc=0x40 while out_valid=1
//     -> out_valid=0 next cycle, then out_pc=0x40.
//     -> redirect_pc=0x42 instead -> fault=1, out_valid=0.
//  4. EBREAK at 0x8
//     -> halted=1 after it loads; out_pc=8 held until accepted; imem_addr=0xC.
//     -> resume -> out_pc=0xC appears.
//  5. Sequential fetch reaching pc=IMEM_WORDS*4 (0x80)
//     -> fault=1, no load of 0x80.
//     -> rst_n=0 one edge -> fault=0, pc=RESET_PC.
//  6. rst_n=0 while out_valid=1 and ready=0 -> out_valid=0 and fetch_count=0 after that edge.

Source files
------------

// File: rtl/minirv_pkg.sv
// Shared types and constants for the miniRV fetch front end.
package minirv_pkg;

   typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} fetch_state_t;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_NOP    = 32'h0000_0013;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, IF/ID handshake, redirect and status.
interface ifetch_ctrl_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        resume;
   logic        halted;
   logic        fault;
   logic [31:0] fetch_count;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output out_valid,
      input  out_ready,
      output out_inst,
      output out_pc,
      input  redirect_valid,
      input  redirect_pc,
      input  resume,
      output halted,
      output fault,
      output fetch_count
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  out_valid,
      output out_ready,
      input  out_inst,
      input  out_pc,
      output redirect_valid,
      output redirect_pc,
      output resume,
      input  halted,
      input  fault,
      input  fetch_count
   );

endinterface

// File: rtl/ifetch_out_reg.sv
// IF/ID output register with valid/ready handshake; flush drops the held entry.
module ifetch_out_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] load_inst,
   input  logic [31:0] load_pc,
   input  logic        ready,
   output logic        valid,
   output logic [31:0] inst,
   output logic [31:0] pc
);

   // Flush wins over load; an accepted entry with nothing behind it empties the stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         inst  <= '0;
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         inst  <= load_inst;
         pc    <= load_pc;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// miniRV instruction fetch: owns the PC, sequences imem, handles redirect/EBREAK/fault.
module ifetch_ctrl
   import minirv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   ifetch_ctrl_if.master       bus
);

   localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  pc;
   logic [31:0]  fetch_count;
   logic         pc_legal;
   logic         redirect_ok;
   logic         load;
   logic         flush;
   logic         halted;
   logic         fault;
   logic         out_valid;
   logic [31:0]  out_inst;
   logic [31:0]  out_pc;

   assign pc_legal    = pc < PC_LIMIT;
   assign redirect_ok = bus.redirect_pc[1:0] == 2'b00;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_next;
   end

   // Redirect outranks address checking, which outranks the EBREAK check on the loaded word.
   always_comb begin
      state_next = state;
      case (state)
         BOOT: state_next = RUN;
         RUN: begin
            if (bus.redirect_valid) begin
               if (!redirect_ok) state_next = FAULT;
            end else if (!pc_legal) begin
               state_next = FAULT;
            end else if (load && bus.imem_rdata == INST_EBREAK) begin
               state_next = HALT;
            end
         end
         HALT: begin
            if (bus.resume && !bus.redirect_valid) state_next = RUN;
         end
         FAULT:   state_next = FAULT;
         default: state_next = state;
      endcase
   end

   always_comb begin
      load   = 1'b0;
      flush  = 1'b0;
      halted = 1'b0;
      fault  = 1'b0;
      case (state)
         RUN: begin
            flush = bus.redirect_valid;
            load  = !bus.redirect_valid && pc_legal && (!out_valid || bus.out_ready);
         end
         HALT:    halted = 1'b1;
         FAULT:   fault  = 1'b1;
         default: ;
      endcase
   end

   // A misaligned redirect still flushes but leaves the PC where it was.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         fetch_count <= '0;
      end else if (flush) begin
         if (redirect_ok) pc <= bus.redirect_pc;
      end else if (load) begin
         pc          <= pc + 32'd4;
         fetch_count <= fetch_count + 32'd1;
      end
   end

   ifetch_out_reg u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .flush     (flush),
      .load_inst (bus.imem_rdata),
      .load_pc   (pc),
      .ready     (bus.out_ready),
      .valid     (out_valid),
      .inst      (out_inst),
      .pc        (out_pc)
   );

   assign bus.imem_addr   = pc;
   assign bus.out_valid   = out_valid;
   assign bus.out_inst    = out_inst;
   assign bus.out_pc      = out_pc;
   assign bus.halted      = halted;
   assign bus.fault       = fault;
   assign bus.fetch_count = fetch_count;

endmodule
